// File: rtl/lcd_pixel_reader.sv
// LCD timing generator that pulls RGB565 pixels from a ready/valid source
// and drives a parallel RGB panel with hsync/vsync/de, flagging underflow.
module lcd_pixel_reader #(
  parameter int unsigned H_ACTIVE        = 320,
  parameter int unsigned H_FP            = 20,
  parameter int unsigned H_SYNC          = 30,
  parameter int unsigned H_BP            = 38,
  parameter int unsigned V_ACTIVE        = 240,
  parameter int unsigned V_FP            = 4,
  parameter int unsigned V_SYNC          = 3,
  parameter int unsigned V_BP            = 15,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF81F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        pixel_ready,
  input  logic        pixel_valid,
  input  logic [15:0] pixel_readdata,
  output logic        pixel_frame_sync,
  output logic        lcd_hsync_n,
  output logic        lcd_vsync_n,
  output logic        lcd_de,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare value of headroom so every boundary constant (up to the total) fits.
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          run;
  logic          h_last_c;
  logic          v_last_c;
  logic          active_c;
  logic          hsync_c;
  logic          vsync_c;

  assign h_last_c = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last_c = (v_cnt == VW'(V_TOTAL - 1));
  assign active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE)) && run;
  assign hsync_c  = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                    (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_c  = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                    (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));

  // Request is issued straight from the registered timing state.
  assign pixel_ready = active_c;

  // Free-running horizontal/vertical position counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Run request only takes effect on a frame boundary, never mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
    end else if (h_last_c && v_last_c) begin
      run <= enable;
    end
  end

  // Registered video timing outputs and frame rewind pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_de           <= 1'b0;
      lcd_hsync_n      <= 1'b1;
      lcd_vsync_n      <= 1'b1;
      pixel_frame_sync <= 1'b0;
    end else begin
      lcd_de           <= active_c;
      lcd_hsync_n      <= ~hsync_c;
      lcd_vsync_n      <= ~vsync_c;
      pixel_frame_sync <= (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
    end
  end

  // Colour path: accepted pixel, underflow marker colour, or black in blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {lcd_r, lcd_g, lcd_b} <= 16'h0000;
    end else if (active_c && pixel_valid) begin
      {lcd_r, lcd_g, lcd_b} <= pixel_readdata;
    end else if (active_c) begin
      {lcd_r, lcd_g, lcd_b} <= UNDERFLOW_COLOR;
    end else begin
      {lcd_r, lcd_g, lcd_b} <= 16'h0000;
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (active_c && !pixel_valid) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_reader.sv
// Randomized scoreboard bench for lcd_pixel_reader using a small raster.
module tb_lcd_pixel_reader;

  localparam int unsigned HA = 8;
  localparam int unsigned HF = 2;
  localparam int unsigned HS = 3;
  localparam int unsigned HB = 2;
  localparam int unsigned VA = 4;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam logic [15:0] UF_COLOR = 16'hF81F;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        pixel_ready;
  logic        pixel_valid;
  logic [15:0] pixel_readdata;
  logic        pixel_frame_sync;
  logic        lcd_hsync_n;
  logic        lcd_vsync_n;
  logic        lcd_de;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic        underflow;
  logic        underflow_clr;

  always #5 clk = ~clk;

  lcd_pixel_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .UNDERFLOW_COLOR(UF_COLOR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pixel_ready(pixel_ready),
    .pixel_valid(pixel_valid),
    .pixel_readdata(pixel_readdata),
    .pixel_frame_sync(pixel_frame_sync),
    .lcd_hsync_n(lcd_hsync_n),
    .lcd_vsync_n(lcd_vsync_n),
    .lcd_de(lcd_de),
    .lcd_r(lcd_r),
    .lcd_g(lcd_g),
    .lcd_b(lcd_b),
    .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  typedef struct {
    logic        de;
    logic        hs_n;
    logic        vs_n;
    logic        fs;
    logic        uf;
    logic [15:0] rgb;
  } exp_t;

  exp_t out_q[$];
  bit   rdy_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: cycle index since reset release, run and flag.
  int   k;
  bit   m_run;
  bit   m_uf;
  bit   rand_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_active(input int kk);
    int h;
    int v;
    h = kk % HT;
    v = (kk / HT) % VT;
    return (h < HA) && (v < VA) && m_run;
  endfunction

  task automatic drive_inputs();
    if (rand_en && $urandom_range(0, 149) == 0) enable = ~enable;
    pixel_valid    = ($urandom_range(0, 11) != 0);
    pixel_readdata = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    underflow_clr  = ($urandom_range(0, 47) == 0);
  endtask

  // Called just after edge k: record what edge k must have produced, advance.
  task automatic step();
    exp_t e;
    int   h;
    int   v;
    bit   act;
    h   = k % HT;
    v   = (k / HT) % VT;
    act = m_active(k);
    e.de   = act;
    e.hs_n = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vs_n = !((v >= VA + VF) && (v < VA + VF + VS));
    e.fs   = (h == 0) && (v == VA);
    e.rgb  = !act ? 16'h0000 : (pixel_valid ? pixel_readdata : UF_COLOR);
    if (act && !pixel_valid) m_uf = 1'b1;
    else if (underflow_clr)  m_uf = 1'b0;
    e.uf = m_uf;
    out_q.push_back(e);
    if (k % FRAME == FRAME - 1) m_run = enable;
    k++;
    drive_inputs();
    rdy_q.push_back(m_active(k));
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 step();
    end
  endtask

  task automatic check_reset_values();
    chk("rst_pixel_ready", 32'(pixel_ready), 32'd0);
    chk("rst_de", 32'(lcd_de), 32'd0);
    chk("rst_hsync_n", 32'(lcd_hsync_n), 32'd1);
    chk("rst_vsync_n", 32'(lcd_vsync_n), 32'd1);
    chk("rst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
    chk("rst_frame_sync", 32'(pixel_frame_sync), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
  endtask

  // Release reset on a clock boundary and restart the model at position 0/0.
  task automatic release_reset();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    k       = 0;
    m_run   = 1'b0;
    m_uf    = 1'b0;
    enable  = 1'b1;
    rand_en = 1'b0;
    drive_inputs();
    rdy_q.push_back(m_active(k));
  endtask

  // Monitor: compare whatever the scoreboard holds against the live outputs.
  always @(negedge clk) begin
    exp_t e;
    bit   r;
    if (!reset) begin
      if (rdy_q.size() > 0) begin
        r = rdy_q.pop_front();
        chk("pixel_ready", 32'(pixel_ready), 32'(r));
      end
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        chk("lcd_de", 32'(lcd_de), 32'(e.de));
        chk("lcd_hsync_n", 32'(lcd_hsync_n), 32'(e.hs_n));
        chk("lcd_vsync_n", 32'(lcd_vsync_n), 32'(e.vs_n));
        chk("frame_sync", 32'(pixel_frame_sync), 32'(e.fs));
        chk("underflow", 32'(underflow), 32'(e.uf));
        chk("rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(e.rgb));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    pixel_valid    = 1'b0;
    pixel_readdata = 16'h0000;
    underflow_clr  = 1'b0;
    rand_en        = 1'b0;
    k              = 0;
    m_run          = 1'b0;
    m_uf           = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_reset_values();

    // Enable held from reset: first frame dark, following frames stream.
    release_reset();
    run_cycles(3 * FRAME);

    // Random enable toggles, including mid-frame changes.
    rand_en = 1'b1;
    run_cycles(8 * FRAME);

    // Enable dropped mid-frame: current frame completes, next one stays dark.
    rand_en = 1'b0;
    enable  = 1'b1;
    run_cycles(FRAME - (k % FRAME) + (VA / 2) * HT);
    enable = 1'b0;
    run_cycles(2 * FRAME);
    enable = 1'b1;
    run_cycles(2 * FRAME);

    // Asynchronous reset in the middle of an active line.
    run_cycles(FRAME - (k % FRAME) + 2 * HT + 5);
    @(posedge clk);
    #3 reset = 1'b1;
    out_q.delete();
    rdy_q.delete();
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #2 check_reset_values();
    release_reset();
    run_cycles(2 * FRAME);
    rand_en = 1'b1;
    run_cycles(4 * FRAME);

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_reader.md
LCD_PIXEL_READER -- requirements
Module: lcd_pixel_reader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- H_ACTIVE, 320, visible pixels per line
- H_FP, 20, horizontal front porch clocks
- H_SYNC, 30, hsync width clocks
- H_BP, 38, horizontal back porch clocks
- V_ACTIVE, 240, visible lines
- V_FP, 4, vertical front porch lines
- V_SYNC, 3, vsync width lines
- V_BP, 15, vertical back porch lines
- UNDERFLOW_COLOR, 16'hF81F, RGB565 value driven on a missing pixel
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, pixel clock (6.4 MHz domain); single clock
- reset, in, 1, asynchronous, active-high reset
- enable, in, 1, run request; sampled only at frame wrap
- pixel_ready, out, 1, request to the pixel source
- pixel_valid, in, 1, source has a pixel on pixel_readdata
- pixel_readdata, in, 16, RGB565 pixel
- pixel_frame_sync, out, 1, one-clock pulse telling the source to rewind to the frame start
- lcd_hsync_n, out, 1, active-low hsync
- lcd_vsync_n, out, 1, active-low vsync
- lcd_de, out, 1, data enable
- lcd_r, out, 5, red
- lcd_g, out, 6, green
- lcd_b, out, 5, blue
- underflow, out, 1, sticky error flag
- underflow_clr, in, 1, clears underflow

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (408); it SHALL wrap to 0 and increment v_cnt.
REQ-004 v_cnt SHALL count 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (262), and SHALL wrap to 0 after the last line; the counters SHALL run continuously, independent of enable.
REQ-005 The run register SHALL load enable only in the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; a mid-frame enable change SHALL have no effect until the next frame.
REQ-006 active SHALL be (h_cnt<H_ACTIVE) AND (v_cnt<V_ACTIVE) AND run.
REQ-007 pixel_ready SHALL equal active (combinational from registers); a pixel SHALL be consumed only when pixel_ready and pixel_valid are both 1.
REQ-008 Video outputs SHALL be registered with exactly one clock of latency from the counters:
- lcd_de <= active
- lcd_hsync_n <= NOT(H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC)
- lcd_vsync_n <= NOT(V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC)
REQ-009 When active and pixel_valid=1, {lcd_r,lcd_g,lcd_b} SHALL be loaded with pixel_readdata[15:11], [10:5], [4:0] respectively.
REQ-010 When active and pixel_valid=0, the colour outputs SHALL be loaded with UNDERFLOW_COLOR, underflow SHALL be set, and no pixel SHALL be consumed, so the line is shortened by one pixel from the source.
REQ-011 When not active, the colour outputs SHALL be loaded with 0.
REQ-012 pixel_frame_sync SHALL be a registered one-clock pulse, issued in the cycle after h_cnt=0 and v_cnt=V_ACTIVE (start of vertical blanking), and SHALL be issued every frame regardless of run.
REQ-013 underflow SHALL remain set until underflow_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-014 pixel_readdata SHALL be ignored whenever pixel_ready=0.

Reset
REQ-015 While reset=1, the following SHALL hold, independent of clk:
- h_cnt=0, v_cnt=0, run=0
- pixel_ready=0, lcd_de=0, lcd_hsync_n=1, lcd_vsync_n=1
- colour outputs=0, pixel_frame_sync=0, underflow=0
REQ-016 A reset asserted mid-frame SHALL abort the frame immediately; after release, no pixel SHALL be requested until the first frame wrap with enable=1.
REQ-017 Reset SHALL be released synchronously to clk by the integrating system; the block adds no synchronizer.

Verification
REQ-018 enable=1 from reset, source always valid with an incrementing pattern -> first pixel_ready rises at frame 2 (h=0, v=0), lcd_de rises 1 clock later, 320 de clocks per line, 240 de lines, 0 underflow.
REQ-019 Sync timing with default parameters -> lcd_hsync_n low for 30 clocks starting 340 clocks after line start; lcd_vsync_n low for 3 lines starting at line 244; frame period 106896 clocks.
REQ-020 pixel_valid forced low for 1 clock at active pixel 100 -> that pixel shows 16'hF81F, underflow=1 and stays 1; underflow_clr pulse -> 0.
REQ-021 enable dropped at line 120 -> the frame completes normally; the next frame has lcd_de=0 and pixel_ready=0 throughout, while pixel_frame_sync still pulses.
REQ-022 Reset asserted at h=200, v=50 -> all outputs take their reset values in the same clock; after release, counters restart at 0/0.
REQ-023 pixel_readdata=16'hFFFF with valid=1 -> lcd_r=31, lcd_g=63, lcd_b=31 one clock after the accepting cycle.
